// File: rtl/regfile_inexrecur_dp.sv
// regfile_inexrecur_dp
//
// Append-only entry store for the inexact-recursion engine. Each entry packs the
// i, z, k and l recursion parameters (four DATA_WIDTH/4-bit fields). The store is
// filled once per recursion pass and is emptied with a synchronous clear.
//
// There are two independent read ports. Both can be used in the same cycle:
//   - sequential port: streams entries in write order from seq_ptr. It can be rewound.
//   - random port:     reads any address. Unwritten addresses return an error flag.
// Both read ports return a registered result one cycle after the request, with a
// valid flag and an address tag.
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   clear              synchronous clear of pointers, flags and valids
//   we, w_data         append request and data
//   seq_re             sequential read request
//   seq_rewind         restart the sequential stream at entry 0
//   seq_r_data/addr    sequential read result and its address
//   seq_r_valid        sequential result valid
//   ran_re, ran_r_addr random read request and address
//   ran_r_data         random read result
//   ran_r_addr_out     address of ran_r_data
//   ran_r_valid        random result valid
//   ran_r_err          random read hit an unwritten entry
//   count              number of written entries
//   full, seq_empty    occupancy status
//   overflow           sticky: write attempted while full
//   underflow          sticky: sequential read attempted while empty

module regfile_inexrecur_dp #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DEPTH      = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  seq_re,
    input  logic                  seq_rewind,
    output logic [DATA_WIDTH-1:0] seq_r_data,
    output logic [ADDR_WIDTH-1:0] seq_r_addr,
    output logic                  seq_r_valid,
    input  logic                  ran_re,
    input  logic [ADDR_WIDTH-1:0] ran_r_addr,
    output logic [DATA_WIDTH-1:0] ran_r_data,
    output logic [ADDR_WIDTH-1:0] ran_r_addr_out,
    output logic                  ran_r_valid,
    output logic                  ran_r_err,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  seq_empty,
    output logic                  overflow,
    output logic                  underflow
);

    // Pointers carry one extra bit so that "full" (== DEPTH) can be represented.
    localparam int unsigned PtrWidth = ADDR_WIDTH + 1;
    localparam int unsigned IdxWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PtrWidth-1:0] DepthPtr = PtrWidth'(DEPTH);

    // Storage. It is not reset: contents are only observable below wr_ptr.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]   seq_ptr_q, seq_ptr_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic [DATA_WIDTH-1:0] seq_data_q, seq_data_d;
    logic [ADDR_WIDTH-1:0] seq_addr_q, seq_addr_d;
    logic                  seq_valid_q, seq_valid_d;

    logic [DATA_WIDTH-1:0] ran_data_q, ran_data_d;
    logic [ADDR_WIDTH-1:0] ran_addr_q, ran_addr_d;
    logic                  ran_valid_q, ran_valid_d;
    logic                  ran_err_q, ran_err_d;

    logic                  full_int;
    logic                  seq_empty_int;
    logic                  wr_accept;
    logic [PtrWidth-1:0]   ran_addr_ext;
    logic [IdxWidth-1:0]   wr_idx;
    logic [IdxWidth-1:0]   seq_idx;
    logic [IdxWidth-1:0]   ran_idx;

    // Status is combinational from the pointers. seq_empty is therefore sampled
    // before any same-cycle write lands.
    assign full_int      = (wr_ptr_q == DepthPtr);
    assign seq_empty_int = (seq_ptr_q == wr_ptr_q);
    assign wr_accept     = we && !full_int && !clear;
    assign ran_addr_ext  = {1'b0, ran_r_addr};

    assign wr_idx  = wr_ptr_q[IdxWidth-1:0];
    assign seq_idx = seq_ptr_q[IdxWidth-1:0];
    assign ran_idx = ran_r_addr[IdxWidth-1:0];

    // ---------------------------------------------------------------------
    // Memory write port
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_idx] <= w_data;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        seq_ptr_d   = seq_ptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        // Valids are one-cycle pulses. Data and address tags hold by default.
        seq_valid_d = 1'b0;
        seq_data_d  = seq_data_q;
        seq_addr_d  = seq_addr_q;

        ran_valid_d = 1'b0;
        ran_err_d   = 1'b0;
        ran_data_d  = ran_data_q;
        ran_addr_d  = ran_addr_q;

        if (clear) begin
            // Clear discards every other request in the same cycle.
            wr_ptr_d    = '0;
            seq_ptr_d   = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            // Append
            if (we) begin
                if (!full_int) begin
                    wr_ptr_d = wr_ptr_q + PtrWidth'(1);
                end else begin
                    overflow_d = 1'b1;
                end
            end

            // Sequential stream. A rewind wins over a same-cycle read.
            if (seq_rewind) begin
                seq_ptr_d = '0;
            end else if (seq_re) begin
                if (!seq_empty_int) begin
                    seq_valid_d = 1'b1;
                    seq_data_d  = mem[seq_idx];
                    seq_addr_d  = seq_ptr_q[ADDR_WIDTH-1:0];
                    seq_ptr_d   = seq_ptr_q + PtrWidth'(1);
                end else begin
                    underflow_d = 1'b1;
                end
            end

            // Random port. A read of the slot being appended this cycle
            // forwards the incoming word.
            if (ran_re) begin
                ran_valid_d = 1'b1;
                ran_addr_d  = ran_r_addr;
                if (ran_addr_ext < wr_ptr_q) begin
                    ran_data_d = mem[ran_idx];
                end else if ((ran_addr_ext == wr_ptr_q) && wr_accept) begin
                    ran_data_d = w_data;
                end else begin
                    ran_data_d = '0;
                    ran_err_d  = 1'b1;
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // State and output registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            seq_ptr_q   <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            seq_data_q  <= '0;
            seq_addr_q  <= '0;
            seq_valid_q <= 1'b0;
            ran_data_q  <= '0;
            ran_addr_q  <= '0;
            ran_valid_q <= 1'b0;
            ran_err_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            seq_ptr_q   <= seq_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            seq_data_q  <= seq_data_d;
            seq_addr_q  <= seq_addr_d;
            seq_valid_q <= seq_valid_d;
            ran_data_q  <= ran_data_d;
            ran_addr_q  <= ran_addr_d;
            ran_valid_q <= ran_valid_d;
            ran_err_q   <= ran_err_d;
        end
    end

    assign seq_r_data     = seq_data_q;
    assign seq_r_addr     = seq_addr_q;
    assign seq_r_valid    = seq_valid_q;
    assign ran_r_data     = ran_data_q;
    assign ran_r_addr_out = ran_addr_q;
    assign ran_r_valid    = ran_valid_q;
    assign ran_r_err      = ran_err_q;
    assign count          = wr_ptr_q;
    assign full           = full_int;
    assign seq_empty      = seq_empty_int;
    assign overflow       = overflow_q;
    assign underflow      = underflow_q;

endmodule

// File: doc/regfile_inexrecur_dp.md
Name: regfile_inexrecur_dp

Overview:
- Parametrised dual-read-port entry store for the inexact-recursion engine. Each entry packs the i, z, k and l recursion parameters.
- Supports append-only writes, a sequential read stream and an independent random read port. The two read ports may be used in the same cycle.
- Both read ports have registered outputs with valid and address tags. There are no tri-state outputs.
- Adds occupancy, full/empty, a sequential rewind, a synchronous clear and sticky error flags.

Parameters:
- DATA_WIDTH, 32, entry width in bits (4 fields of DATA_WIDTH/4 bits).
- ADDR_WIDTH, 12, address width. DEPTH must be at most 2**ADDR_WIDTH.
- DEPTH, 4096, number of entries.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous clear of pointers and flags.
- we  in  1  write (append) enable.
- w_data  in  DATA_WIDTH  write data.
- seq_re  in  1  sequential read request.
- seq_rewind  in  1  restart the sequential stream at entry 0.
- seq_r_data  out  DATA_WIDTH  sequential read data.
- seq_r_addr  out  ADDR_WIDTH  address of seq_r_data.
- seq_r_valid  out  1  seq_r_data/seq_r_addr valid this cycle.
- ran_re  in  1  random read request.
- ran_r_addr  in  ADDR_WIDTH  random read address.
- ran_r_data  out  DATA_WIDTH  random read data.
- ran_r_addr_out  out  ADDR_WIDTH  address of ran_r_data.
- ran_r_valid  out  1  random read result valid.
- ran_r_err  out  1  random read hit an unwritten entry (qualifies ran_r_valid).
- count  out  ADDR_WIDTH+1  number of written entries.
- full  out  1  count == DEPTH.
- seq_empty  out  1  sequential pointer == write pointer.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: seq_re while seq_empty.

Behaviour:
- Reset (rst_n=0, asynchronous): every output is 0 except seq_empty, which is 1. Pointers are cleared. Memory contents are undefined.
- Internal state: wr_ptr and seq_ptr, each ADDR_WIDTH+1 bits. count = wr_ptr; full = (wr_ptr == DEPTH); seq_empty = (seq_ptr == wr_ptr). These outputs are combinational from the pointers.
- Write: when we && !full, mem[wr_ptr] <= w_data and wr_ptr increments. When we && full, the write is dropped, wr_ptr holds and overflow is set.
- Sequential read, latency 1:
  - When seq_re && !seq_empty: next cycle seq_r_data = mem[seq_ptr], seq_r_addr = seq_ptr and seq_r_valid = 1; seq_ptr increments.
  - When seq_re && seq_empty: seq_r_valid = 0 next cycle, underflow is set and seq_ptr holds.
  - seq_empty is evaluated before the same-cycle write. A word written in cycle N is first seq-readable in cycle N+1.
- Random read, latency 1:
  - When ran_re: next cycle ran_r_valid = 1 and ran_r_addr_out = ran_r_addr.
  - If ran_r_addr < wr_ptr, ran_r_data = mem[ran_r_addr] and ran_r_err = 0.
  - If ran_r_addr == wr_ptr and a write is accepted this cycle, w_data is bypassed to ran_r_data and ran_r_err = 0.
  - Otherwise ran_r_data = 0 and ran_r_err = 1.
- Both read ports operate independently and concurrently. A random read never moves seq_ptr.
- Output hold: when no read is accepted on a port, that port's valid drops to 0 the next cycle. Its data and address outputs hold their last values.
- seq_rewind: seq_ptr <= 0 and seq_r_valid = 0 next cycle. It takes priority over a same-cycle seq_re, which is ignored and does not set underflow.
- clear:
  - wr_ptr, seq_ptr, overflow, underflow and both valids go to 0. Memory is not cleared.
  - clear has priority over we, seq_re, seq_rewind and ran_re in the same cycle; those requests are discarded.
- Simultaneous we and seq_re on a one-entry-remaining store is legal: both complete in the same cycle.
- Pointers never wrap. The store is filled once per recursion pass and reset with clear.
- Reset asserted mid-operation forces the reset state immediately. Operations in flight are lost.

Test Plan:
1. DEPTH=4, ADDR_WIDTH=2. Write 0x11223344, 0x55667788, 0x99AABBCC, 0xDDEEFF00; then 4 seq_re cycles → seq_r_valid high for 4 cycles with addr 0..3 and matching data, count=4, full=1, seq_empty=1.
2. Store full, we with 0xCAFEBABE → count stays 4, overflow=1, mem[0] still 0x11223344; a fifth seq_re → seq_r_valid=0, underflow=1.
3. Write 2 entries. In the same cycle, seq_re plus ran_re with addr 1 → next cycle seq data = entry0 at addr 0, ran data = entry1 at addr 1, both valid.
4. Random reads:
   - count=2, ran_re addr 3 → ran_r_valid=1, ran_r_err=1, data 0.
   - ran_re addr 2 with we 0x0BADF00D in the same cycle → data 0x0BADF00D, err=0.
5. After 3 seq reads, seq_rewind together with seq_re → seq_r_valid=0, no underflow. The next seq_re returns addr 0, entry0.
6. clear with we in the same cycle → count=0, flags 0, the write is discarded. rst_n pulsed low mid-stream → all outputs 0 except seq_empty=1 immediately, without waiting for a clock edge.
